// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the rr_mux_reg channel multiplexer.
// Optional burst locking is enabled by defining RR_MUX_LAST_EN.
package rr_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   function automatic int unsigned chan_count(input int unsigned sel_w);
      return 32'd1 << sel_w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or above rr_ptr_i, wrapping to channel 0.
// With RR_MUX_LAST_EN defined, an active lock restricts the grant to lock_chan_i.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int unsigned n = 3
) (
   input  logic [chan_count(n)-1:0] req_i,
   input  logic [n-1:0]             rr_ptr_i,
`ifdef RR_MUX_LAST_EN
   input  logic                     lock_i,
   input  logic [n-1:0]             lock_chan_i,
`endif
   output logic [chan_count(n)-1:0] grant_o,
   output logic [n-1:0]             grant_idx_o
);

   localparam int unsigned Chans = chan_count(n);

   logic [n-1:0] idx;
   logic         found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      idx         = '0;
      found       = 1'b0;
`ifdef RR_MUX_LAST_EN
      if (lock_i) begin
         // Mid-burst: only the locked channel may continue.
         if (req_i[lock_chan_i]) begin
            grant_o[lock_chan_i] = 1'b1;
            grant_idx_o          = lock_chan_i;
         end
      end else begin
`else
      begin
`endif
         for (int k = 0; k < Chans; k++) begin
            idx = rr_ptr_i + n'(k);
            if (!found && req_i[idx]) begin
               found        = 1'b1;
               grant_o[idx] = 1'b1;
               grant_idx_o  = idx;
            end
         end
      end
   end

endmodule

// File: rtl/rr_mux_reg.sv
// Registered 2**n-channel mux with valid/ready handshakes, fixed or round-robin select.
// Define RR_MUX_LAST_EN to add in_last/out_last and burst-locked round-robin arbitration.
module rr_mux_reg
   import rr_mux_pkg::*;
#(
   parameter int unsigned size = 4,
   parameter int unsigned n    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [size*chan_count(n)-1:0] in,
   input  logic [chan_count(n)-1:0]      in_valid,
`ifdef RR_MUX_LAST_EN
   input  logic [chan_count(n)-1:0]      in_last,
`endif
   output logic [chan_count(n)-1:0]      in_ready,
   input  logic                          mode,
   input  logic [n-1:0]                  select,
   output logic [size-1:0]               out,
   output logic [n-1:0]                  out_chan,
   output logic                          out_valid,
`ifdef RR_MUX_LAST_EN
   output logic                          out_last,
`endif
   input  logic                          out_ready
);

   localparam int unsigned Chans = chan_count(n);

   out_state_e      state_q, state_d;
   logic [size-1:0] out_q, out_d;
   logic [n-1:0]    chan_q, chan_d;
   logic [n-1:0]    rr_ptr_q, rr_ptr_d;
`ifdef RR_MUX_LAST_EN
   logic            lock_q, lock_d;
   logic [n-1:0]    lock_chan_q, lock_chan_d;
   logic            last_q, last_d;
`endif

   logic [Chans-1:0] grant, grant_rr;
   logic [n-1:0]     grant_idx, idx_rr;
   logic             can_load, xfer;
   logic [size-1:0]  sel_data;

   rr_arbiter #(
      .n(n)
   ) u_arb (
      .req_i      (in_valid),
      .rr_ptr_i   (rr_ptr_q),
`ifdef RR_MUX_LAST_EN
      .lock_i     (lock_q),
      .lock_chan_i(lock_chan_q),
`endif
      .grant_o    (grant_rr),
      .grant_idx_o(idx_rr)
   );

   always_comb begin
      grant     = '0;
      grant_idx = select;
      if (mode == MODE_RR) begin
         grant     = grant_rr;
         grant_idx = idx_rr;
      end else if (in_valid[select]) begin
         grant[select] = 1'b1;
      end
   end

   // in_ready is held low while reset is asserted so no producer sees a phantom accept.
   assign can_load = (state_q == ST_EMPTY) || out_ready;
   assign in_ready = grant & {Chans{can_load & rst_n}};
   assign xfer     = |in_ready;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < Chans; i++) begin
         if (grant[i]) sel_data = in[size*i +: size];
      end
   end

   always_comb begin
      state_d  = state_q;
      out_d    = out_q;
      chan_d   = chan_q;
      rr_ptr_d = rr_ptr_q;
`ifdef RR_MUX_LAST_EN
      lock_d      = lock_q;
      lock_chan_d = lock_chan_q;
      last_d      = last_q;
`endif
      if (xfer) begin
         state_d = ST_FULL;
         out_d   = sel_data;
         chan_d  = grant_idx;
`ifdef RR_MUX_LAST_EN
         last_d  = in_last[grant_idx];
         if (mode == MODE_RR) begin
            // Pointer moves past a channel only once its burst has finished.
            if (in_last[grant_idx]) begin
               lock_d   = 1'b0;
               rr_ptr_d = grant_idx + n'(1);
            end else begin
               lock_d      = 1'b1;
               lock_chan_d = grant_idx;
            end
         end
`else
         if (mode == MODE_RR) rr_ptr_d = grant_idx + n'(1);
`endif
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         chan_q      <= '0;
         rr_ptr_q    <= '0;
`ifdef RR_MUX_LAST_EN
         lock_q      <= 1'b0;
         lock_chan_q <= '0;
         last_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         chan_q      <= chan_d;
         rr_ptr_q    <= rr_ptr_d;
`ifdef RR_MUX_LAST_EN
         lock_q      <= lock_d;
         lock_chan_q <= lock_chan_d;
         last_q      <= last_d;
`endif
      end
   end

   assign out       = out_q;
   assign out_chan  = chan_q;
   assign out_valid = (state_q == ST_FULL);
`ifdef RR_MUX_LAST_EN
   assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg (size=4, n=3); also covers RR_MUX_LAST_EN when defined.
module tb_rr_mux_reg;

   localparam int CH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] din;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic        mode;
   logic [2:0]  select;
   logic [3:0]  dout;
   logic [2:0]  out_chan;
   logic        out_valid;
   logic        out_ready;
`ifdef RR_MUX_LAST_EN
   logic [7:0]  in_last;
   logic        out_last;
`endif

   always #5 clk = ~clk;

   rr_mux_reg #(
      .size(4),
      .n   (3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (din),
      .in_valid (in_valid),
`ifdef RR_MUX_LAST_EN
      .in_last  (in_last),
`endif
      .in_ready (in_ready),
      .mode     (mode),
      .select   (select),
      .out      (dout),
      .out_chan (out_chan),
      .out_valid(out_valid),
`ifdef RR_MUX_LAST_EN
      .out_last (out_last),
`endif
      .out_ready(out_ready)
   );

   typedef struct {
      logic [3:0] data;
      logic [2:0] chan;
      logic       last;
   } beat_t;

   beat_t sb[$];
   int    total = 0;
   int    bad   = 0;
   bit    exp_valid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: evaluates the arbitration rules on stable inputs at negedge,
   // pushes the accepted beat at the following posedge.
   initial begin : model
      int    m_ptr;
      bit    m_full;
      bit    m_lock;
      int    m_lock_chan;
      int    g;
      bit    xfer;
      beat_t b;
      m_ptr = 0; m_full = 0; m_lock = 0; m_lock_chan = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_ptr = 0; m_full = 0; m_lock = 0; m_lock_chan = 0;
            exp_valid = 1'b0;
            sb.delete();
            continue;
         end
         g = -1;
         if (mode == 1'b0) begin
            if (in_valid[select]) g = int'(select);
         end else if (m_lock) begin
            if (in_valid[m_lock_chan]) g = m_lock_chan;
         end else begin
            for (int k = 0; k < CH; k++)
               if (g < 0 && in_valid[(m_ptr + k) % CH]) g = (m_ptr + k) % CH;
         end
         xfer = (g >= 0) && (!m_full || out_ready);
         check("in_ready", {24'd0, in_ready}, xfer ? (32'd1 << g) : 32'd0);
         if (xfer) begin
            b.data = din[g*4 +: 4];
            b.chan = 3'(g);
            b.last = 1'b0;
`ifdef RR_MUX_LAST_EN
            b.last = in_last[g];
            if (mode == 1'b1) begin
               if (in_last[g]) begin
                  m_lock = 0;
                  m_ptr  = (g + 1) % CH;
               end else begin
                  m_lock      = 1;
                  m_lock_chan = g;
               end
            end
`else
            if (mode == 1'b1) m_ptr = (g + 1) % CH;
`endif
            m_full = 1;
         end else if (out_ready) begin
            m_full = 0;
         end
         @(posedge clk);
         if (rst_n) begin
            if (xfer) sb.push_back(b);
            exp_valid = m_full;
         end
      end
   end

   // Monitor: compares the presented beat against the queue head, pops on consumption.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
            if (exp_valid && sb.size() > 0) begin
               check("out", {28'd0, dout}, {28'd0, sb[0].data});
               check("out_chan", {29'd0, out_chan}, {29'd0, sb[0].chan});
`ifdef RR_MUX_LAST_EN
               check("out_last", {31'd0, out_last}, {31'd0, sb[0].last});
`endif
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      rst_n     = 1'b0;
      din       = $urandom;
      in_valid  = $urandom;
      mode      = 1'b1;
      select    = 3'($urandom);
      out_ready = 1'b0;
`ifdef RR_MUX_LAST_EN
      in_last   = $urandom;
`endif
      repeat (3) step();
      check("rst_out", {28'd0, dout}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {24'd0, in_ready}, 32'd0);
      in_valid = 8'h00;
      step();
      rst_n = 1'b1;
      repeat (3) step();

      // Fixed select stepping through every channel.
      din       = 32'h7654_3210;
      mode      = 1'b0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
`ifdef RR_MUX_LAST_EN
      in_last   = 8'hFF;
`endif
      for (int i = 0; i < CH; i++) begin
         select = 3'(i);
         step();
      end
      in_valid = 8'hDF;
      select   = 3'd5;
      step();
      check("fixed_unselected_ready", {24'd0, in_ready}, 32'd0);
      step();
      check("fixed_valid_falls", {31'd0, out_valid}, 32'd0);

      // Round-robin fairness over a sparse request set.
      mode     = 1'b1;
      in_valid = 8'b1010_0101;
      repeat (12) step();

      // Backpressure after one beat.
      in_valid = 8'h00;
      repeat (2) step();
      in_valid = 8'hFF;
      step();
      out_ready = 1'b0;
      repeat (3) step();
      out_ready = 1'b1;
      repeat (4) step();

      // Pointer wrap, then a fixed-mode beat that must leave the pointer alone.
      in_valid = 8'h40;
      step();
      in_valid = 8'h81;
      repeat (2) step();
      mode     = 1'b0;
      select   = 3'd3;
      in_valid = 8'h08;
      step();
      in_valid = 8'h00;
      step();
      mode     = 1'b1;
      in_valid = 8'hFF;
      repeat (3) step();

      // Asynchronous reset while holding a stalled beat.
      out_ready = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_out", {28'd0, dout}, 32'd0);
      repeat (2) step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (4) step();

`ifdef RR_MUX_LAST_EN
      // Burst on channel 2 must not be interrupted by channel 3.
      in_valid = 8'h00;
      step();
      in_last  = 8'h00;
      in_valid = 8'h04;
      step();
      in_valid = 8'h0C;
      step();
      in_last  = 8'h04;
      step();
      in_last  = 8'hFF;
      repeat (3) step();
`endif

      // Randomised traffic with occasional mode switches and backpressure.
      for (int i = 0; i < 400; i++) begin
         din       = $urandom;
         in_valid  = 8'($urandom);
         mode      = ($urandom_range(0, 7) != 0);
         select    = 3'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_MUX_LAST_EN
         in_last   = 8'($urandom);
`endif
         step();
      end

      in_valid  = 8'h00;
      out_ready = 1'b1;
      repeat (3) step();
      check("sb_drained", sb.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
